// File: rtl/fifo_pkg.sv
// Shared dual-clock FIFO helpers: pointer-code conversions and the default
// address width used by both pointer blocks and the synchronizers.
package fifo_pkg;

    localparam int DEF_ADDRSIZE = 4;

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Prefix XOR by doubling shifts; valid for any zero-extended width up to 32.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin = gray;
        bin = bin ^ (bin >> 1);
        bin = bin ^ (bin >> 2);
        bin = bin ^ (bin >> 4);
        bin = bin ^ (bin >> 8);
        bin = bin ^ (bin >> 16);
        return bin;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all
// Gray bits at or above its position.
module fifo_gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and status controller of the dual-clock FIFO (wclk domain):
// binary/Gray write pointer, full, almost-full, fill level and sticky overflow.
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE    = DEF_ADDRSIZE,
    parameter int AFULL_LEVEL = 14
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic                wovf_clr,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    output logic                wen,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                woverflow
);

    localparam logic [ADDRSIZE:0] AFULL_W = AFULL_LEVEL[ADDRSIZE:0];

    logic [ADDRSIZE:0] wbin_r;
    logic [ADDRSIZE:0] wptr_r;
    logic              wfull_r;
    logic              walmost_full_r;
    logic [ADDRSIZE:0] wlevel_r;
    logic              woverflow_r;

    logic              inc_s;
    logic [ADDRSIZE:0] wbinnext_s;
    logic [ADDRSIZE:0] wgraynext_s;
    logic [ADDRSIZE:0] rbin_s;
    logic [ADDRSIZE:0] level_next_s;
    logic [ADDRSIZE:0] full_ptr_s;

    fifo_gray2bin #(
        .W (ADDRSIZE + 1)
    ) u_rptr_g2b (
        .gray (wq2_rptr),
        .bin  (rbin_s)
    );

    assign inc_s        = winc & ~wfull_r;
    assign wbinnext_s   = wbin_r + {{ADDRSIZE{1'b0}}, inc_s};
    assign wgraynext_s  = wbinnext_s ^ (wbinnext_s >> 1);
    assign level_next_s = wbinnext_s - rbin_s;
    // Full when the write pointer is one lap ahead: top two Gray bits inverted.
    assign full_ptr_s   = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};

    // Pointer, flag and level state; all updated from the same next-state view.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin_r         <= '0;
            wptr_r         <= '0;
            wfull_r        <= 1'b0;
            walmost_full_r <= 1'b0;
            wlevel_r       <= '0;
            woverflow_r    <= 1'b0;
        end else begin
            wbin_r         <= wbinnext_s;
            wptr_r         <= wgraynext_s;
            wfull_r        <= (wgraynext_s == full_ptr_s);
            walmost_full_r <= (level_next_s >= AFULL_W);
            wlevel_r       <= level_next_s;
            if (winc && wfull_r) begin
                woverflow_r <= 1'b1;
            end else if (wovf_clr) begin
                woverflow_r <= 1'b0;
            end else begin
                woverflow_r <= woverflow_r;
            end
        end
    end

    // Enable is gated by reset so no RAM write can slip through while it is held.
    assign wen          = inc_s & ~wrst;
    assign waddr        = wbin_r[ADDRSIZE-1:0];
    assign wptr         = wptr_r;
    assign wfull        = wfull_r;
    assign walmost_full = walmost_full_r;
    assign wlevel       = wlevel_r;
    assign woverflow    = woverflow_r;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Scoreboard bench for wptr_full_ctrl: a count-based occupancy model predicts
// each cycle's outputs, a negedge monitor pops and compares them.
module tb_wptr_full_ctrl;

    logic       wclk = 1'b0;
    logic       wrst;
    logic       winc;
    logic       wovf_clr;
    logic [4:0] wq2_rptr;
    logic       wen;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
    logic       woverflow;

    wptr_full_ctrl #(.ADDRSIZE(4), .AFULL_LEVEL(14)) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .winc         (winc),
        .wovf_clr     (wovf_clr),
        .wq2_rptr     (wq2_rptr),
        .wen          (wen),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .woverflow    (woverflow)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic       wen;
        logic [3:0] waddr;
        logic [4:0] wptr;
        logic       full;
        logic       af;
        logic [4:0] lvl;
        logic       ovf;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Reference model: total words written and read, as plain integers.
    int   m_wcount = 0;
    int   rcount   = 0;
    int   m_lvl    = 0;
    bit   m_full   = 1'b0;
    bit   m_af     = 1'b0;
    bit   m_ovf    = 1'b0;

    function automatic logic [4:0] gray5(input int v);
        logic [4:0] b;
        b = v[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: drive inputs, queue the expectation, advance the model.
    task automatic step(input bit wi, input bit clr, input int rd);
        exp_t e;
        @(posedge wclk);
        #2;
        rcount = rcount + rd;
        if (rcount > m_wcount) rcount = m_wcount;
        wq2_rptr = gray5(rcount);
        winc     = wi;
        wovf_clr = clr;
        e.wen   = wi && !m_full;
        e.waddr = m_wcount[3:0];
        e.wptr  = gray5(m_wcount);
        e.full  = m_full;
        e.af    = m_af;
        e.lvl   = m_lvl[4:0];
        e.ovf   = m_ovf;
        q.push_back(e);
        if (wi && m_full) m_ovf = 1'b1;
        else if (clr)     m_ovf = 1'b0;
        if (wi && !m_full) m_wcount++;
        m_lvl  = m_wcount - rcount;
        m_full = (m_lvl == 16);
        m_af   = (m_lvl >= 14);
    endtask

    // Assert reset between edges with a write pending and check it acts at once.
    task automatic do_reset();
        @(negedge wclk);
        #1;
        if (q.size() != 0) chk("queue_drain", q.size(), 0);
        q.delete();
        winc = 1'b1;
        wrst = 1'b1;
        #1;
        chk("rst_wptr",  wptr, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wen",   wen, 0);
        chk("rst_wfull", wfull, 0);
        chk("rst_afull", walmost_full, 0);
        chk("rst_wlevel", wlevel, 0);
        chk("rst_wovf",  woverflow, 0);
        m_wcount = 0; rcount = 0; m_lvl = 0;
        m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
        wq2_rptr = 5'd0;
        winc     = 1'b0;
        wovf_clr = 1'b0;
        @(posedge wclk);
        #2;
        wrst = 1'b0;
    endtask

    // Monitor: compare each queued expectation with the settled outputs.
    always @(negedge wclk) begin
        exp_t e;
        if (!wrst && q.size() > 0) begin
            e = q.pop_front();
            chk("wen",          wen, e.wen);
            chk("waddr",        waddr, e.waddr);
            chk("wptr",         wptr, e.wptr);
            chk("wfull",        wfull, e.full);
            chk("walmost_full", walmost_full, e.af);
            chk("wlevel",       wlevel, e.lvl);
            chk("woverflow",    woverflow, e.ovf);
        end
    end

    initial begin
        wrst = 1'b1; winc = 1'b0; wovf_clr = 1'b0; wq2_rptr = 5'd0;
        repeat (3) @(posedge wclk);
        #2;
        wrst = 1'b0;

        // Mid-burst reset, then first write lands at address 0.
        repeat (5) step(1'b1, 1'b0, 0);
        do_reset();
        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 0);

        // Fill from empty, overflow handling, release.
        do_reset();
        repeat (16) step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 0);
        step(1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 1);
        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 0);

        // Wrap: half-lap offset, read pointer jumps, refill across 31->0.
        do_reset();
        repeat (16) step(1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 16);
        repeat (16) step(1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 0);

        // Simultaneous write and read advance at level 15.
        step(1'b0, 1'b0, 1);
        step(1'b1, 1'b0, 1);
        step(1'b0, 1'b0, 0);

        // Randomized traffic including multi-word read pointer jumps.
        for (int i = 0; i < 600; i++) begin
            bit wi, clr;
            int rd;
            wi  = ($urandom % 10) < 7;
            clr = ($urandom % 10) == 0;
            if (($urandom % 100) < 5) rd = $urandom_range(0, 16);
            else                      rd = (($urandom % 10) < 4) ? 1 : 0;
            step(wi, clr, rd);
        end
        step(1'b0, 1'b0, 0);

        @(negedge wclk);
        #1;
        if (q.size() != 0) chk("final_drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/wptr_full_ctrl.md
Name: wptr_full_ctrl

Overview:
Write-side pointer and status controller for the dual-clock FIFO, in the wclk domain.
- Consumes the read pointer already synchronized into wclk (wq2_rptr).
- Produces the RAM write address and enable, and the Gray write pointer sent to the read-side synchronizer.
- Flags: full, almost-full, fill level and sticky overflow.

Parameters:
ADDRSIZE, 4, FIFO address width; depth = 2^ADDRSIZE; legal ADDRSIZE >= 2.
AFULL_LEVEL, 14, fill level at or above which walmost_full asserts; legal 1..2^ADDRSIZE.

Ports:
wclk  in  1  write-domain clock; all state on rising edge.
wrst  in  1  asynchronous active-high reset.
winc  in  1  write request for the current cycle.
wovf_clr  in  1  clears woverflow.
wq2_rptr  in  ADDRSIZE+1  Gray read pointer, already double-synchronized into wclk.
wen  out  1  RAM write enable = winc & ~wfull (combinational).
waddr  out  ADDRSIZE  binary RAM write address = wbin[ADDRSIZE-1:0].
wptr  out  ADDRSIZE+1  registered Gray write pointer, to the read-side synchronizer.
wfull  out  1  registered full flag.
walmost_full  out  1  registered almost-full flag.
wlevel  out  ADDRSIZE+1  registered fill count, 0..2^ADDRSIZE.
woverflow  out  1  sticky: a write was attempted while full.

Behaviour:
- State: wbin (ADDRSIZE+1 bit binary pointer), wptr, wfull, walmost_full, wlevel, woverflow. No FSM; the pointer is the state.
- Reset: wrst high clears all registers to 0 immediately, asynchronously, including mid-burst. waddr=0, wen=0 while wrst is high.
- Pointer update:
  - wbinnext = wbin + (winc & ~wfull), modulo 2^(ADDRSIZE+1).
  - wgraynext = wbinnext ^ (wbinnext >> 1).
  - Each edge: wbin <= wbinnext, wptr <= wgraynext.
  - Write when full: wbin and wptr hold.
- Full: wfull <= (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
  - Asserts on the same edge as the write that fills the last slot; no extra latency.
- Level:
  - rbin = Gray-to-binary of wq2_rptr (combinational).
  - wlevel <= (wbinnext - rbin), modulo 2^(ADDRSIZE+1).
  - Always 0..2^ADDRSIZE given a legal wq2_rptr.
- Almost-full: walmost_full <= (wbinnext - rbin) >= AFULL_LEVEL.
- Overflow:
  - woverflow sets when winc & wfull.
  - Clears when wovf_clr is high and no set occurs that cycle; set wins on a simultaneous set and clear.
- Pessimism: a read advance appears here 2 wclk after rptr changes (synchronizer), then flags update on the next edge. wfull/walmost_full may stay high longer than true occupancy, never shorter.
- Simultaneous write and wq2_rptr change in one cycle: both go into the same next-state computation. Level is unchanged if each advances by one.
- Wrap-around: wbin rolls from 2^(ADDRSIZE+1)-1 to 0 with no special handling; the Gray MSB-pair inversion resolves full across the wrap.
- Multi-bit wq2_rptr jumps (e.g. after read-side reset): treated as legal input, level recomputed directly.

Decomposition:
- Shared FIFO include/package (fifo_pkg): bin2gray and gray2bin functions parameterized on width, and the default ADDRSIZE constant. The same package is used by the read-side pointer block and both synchronizers.
- One natural sub-module: fifo_gray2bin, a combinational XOR-prefix converter for wq2_rptr, instantiated once; reused by the read-side block.

Test Plan:
All scenarios use ADDRSIZE=4, AFULL_LEVEL=14.
1. Mid-burst reset: after 5 writes assert wrst between edges -> wptr, wfull, walmost_full, wlevel, woverflow drop to 0 immediately and waddr=0. After release the first write goes to waddr=0.
2. Fill from empty: wq2_rptr=0, winc=1 for 16 edges -> waddr 0..15 and wptr Gray sequence 00000,00001,00011,00010,... walmost_full=1 after the 14th edge; wfull=1 and wlevel=16 after the 16th edge; wen=0 thereafter.
3. Overflow: while full, winc=1 for 2 edges -> wptr stays 11000 and woverflow=1. Pulse wovf_clr together with winc -> stays 1. Pulse wovf_clr alone -> 0.
4. Release: while full, set wq2_rptr=00001 (rbin=1) -> next edge wfull=0, wlevel=15, walmost_full=1. One write -> wfull=1, wlevel=16.
5. Wrap: with wbin=16 and wq2_rptr=11000 (rbin=16), write 16 times -> wbin crosses 31->0, final wptr=00000, wfull=1, wlevel=16.
6. Simultaneous advance: at wlevel=15, winc=1 on the same edge wq2_rptr advances by one -> wlevel stays 15, wfull stays 0.
